// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg
//   Shared types and constants for the serial pattern transmitter and the
//   detector benches that consume its output.
//   - state_t       : transmitter FSM states (prefixed to stay clear of the
//                     GAP parameter name used by the top module)
//   - DEF_*         : default parameter values
//   - PAT_0011      : reference pattern for the 0011 sequence detector
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int         DEF_WIDTH      = 4;
    localparam int         DEF_CNT_W      = 8;
    localparam logic       DEF_IDLE_LEVEL = 1'b1;
    localparam logic [3:0] PAT_0011       = 4'b0011;

endpackage

// File: rtl/seq_gen_piso.sv
// seq_gen_piso
//   WIDTH-bit parallel-in serial-out shift register, MSB first.
//   Ports:
//     clk   : rising-edge clock
//     rst   : asynchronous active-high reset (clears the register)
//     load  : capture din (takes priority over shift)
//     shift : shift left by one, zero-filling the LSB
//     din   : parallel load value
//     msb   : current MSB of the register
module seq_gen_piso #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] shift_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= din;
        end else if (shift) begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = shift_reg[WIDTH-1];

endmodule

// File: rtl/seq_gen_serial_tx.sv
// seq_gen_serial_tx
//   Serial pattern transmitter feeding the w input of a sequence detector.
//   A pattern word is accepted on start && ready and shifted out MSB-first,
//   repeated count times (0 means once) with GAP idle cycles between repeats.
//   Ports:
//     Clock   : rising-edge clock
//     Reset   : asynchronous active-high reset
//     start   : transmit request, accepted when ready is high
//     data    : pattern word, captured on acceptance
//     count   : repeat count, captured on acceptance
//     ready   : high only while idle
//     w       : serial bit to the detector (IDLE_LEVEL when not transmitting)
//     w_valid : high while w carries a pattern bit
//     done    : one-cycle pulse in the first idle cycle after the last bit
module seq_gen_serial_tx
    import seq_gen_pkg::*;
#(
    parameter int   WIDTH      = DEF_WIDTH,
    parameter int   CNT_W      = DEF_CNT_W,
    parameter int   GAP        = 0,
    parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [CNT_W-1:0] count,
    output logic             ready,
    output logic             w,
    output logic             w_valid,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_t           state, state_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt;
    logic [CNT_W-1:0] rep_cnt, rep_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [WIDTH-1:0] hold_reg;
    logic [WIDTH-1:0] load_val;
    logic             load, shift, done_nxt, msb;

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        rep_nxt   = rep_cnt;
        gap_nxt   = gap_cnt;
        load      = 1'b0;
        shift     = 1'b0;
        done_nxt  = 1'b0;
        // The first load takes the live input; repeats reload the held copy.
        load_val  = (state == ST_IDLE) ? data : hold_reg;

        case (state)
            ST_IDLE: begin
                if (start && ready) begin
                    load      = 1'b1;
                    rep_nxt   = (count == '0) ? CNT_W'(1) : count;
                    bit_nxt   = BIT_W'(WIDTH - 1);
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt == '0) begin
                    if (rep_cnt > CNT_W'(1)) begin
                        rep_nxt = rep_cnt - CNT_W'(1);
                        load    = 1'b1;
                        bit_nxt = BIT_W'(WIDTH - 1);
                        if (GAP != 0) begin
                            gap_nxt   = GAP_W'(GAP - 1);
                            state_nxt = ST_GAP;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    shift   = 1'b1;
                    bit_nxt = bit_cnt - BIT_W'(1);
                end
            end
            ST_GAP: begin
                // Shift register was already reloaded on entry to GAP.
                if (gap_cnt == '0) begin
                    state_nxt = ST_SHIFT;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            ready   <= 1'b1;
            w_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_nxt;
            rep_cnt <= rep_nxt;
            gap_cnt <= gap_nxt;
            ready   <= (state_nxt == ST_IDLE);
            w_valid <= (state_nxt == ST_SHIFT);
            done    <= done_nxt;
        end
    end

    // Pattern copy used for repeats; pure data, so no reset.
    always_ff @(posedge Clock) begin
        if (state == ST_IDLE && start && ready) begin
            hold_reg <= data;
        end
    end

    seq_gen_piso #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk  (Clock),
        .rst  (Reset),
        .load (load),
        .shift(shift),
        .din  (load_val),
        .msb  (msb)
    );

    // w is a select between two flops (w_valid and the shift-register MSB),
    // so it has no combinational path from any input.
    assign w = w_valid ? msb : IDLE_LEVEL;

endmodule

// File: tb/tb_seq_gen_serial_tx.sv
// tb_seq_gen_serial_tx
//   Self-checking bench for seq_gen_serial_tx. Two instances (GAP=0 and
//   GAP=2) share clock and reset; a per-cycle expected trace is built from
//   the pattern/count/gap rules and compared against the selected instance.
module tb_seq_gen_serial_tx;
    import seq_gen_pkg::*;

    localparam int W  = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start0, start2;
    logic [W-1:0]  data0, data2;
    logic [CW-1:0] count0, count2;
    logic          ready0, w0, wv0, done0;
    logic          ready2, w2, wv2, done2;

    seq_gen_serial_tx #(.WIDTH(W), .CNT_W(CW), .GAP(0), .IDLE_LEVEL(1'b1)) dut0 (
        .Clock(clk), .Reset(rst), .start(start0), .data(data0), .count(count0),
        .ready(ready0), .w(w0), .w_valid(wv0), .done(done0)
    );

    seq_gen_serial_tx #(.WIDTH(W), .CNT_W(CW), .GAP(2), .IDLE_LEVEL(1'b1)) dut2 (
        .Clock(clk), .Reset(rst), .start(start2), .data(data2), .count(count2),
        .ready(ready2), .w(w2), .w_valid(wv2), .done(done2)
    );

    typedef struct {
        logic w;
        logic v;
        logic rdy;
        logic dn;
    } cyc_t;

    typedef struct {
        int          sel;
        logic [3:0]  d;
        logic [7:0]  c;
        logic [15:0] bits;
        int          nb;
        int          dcyc;
        int          z;
    } vec_t;

    int   sel;
    int   tests = 0;
    int   fails = 0;
    cyc_t exp_q[$];

    logic [63:0] bits;
    int          nb, dc, zc;

    // {ready, w, w_valid, done} of the selected instance
    function automatic logic [3:0] cur();
        if (sel == 2) return {ready2, w2, wv2, done2};
        return {ready0, w0, wv0, done0};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic [3:0] d, input logic [7:0] c);
        start0 = 1'b0; start2 = 1'b0;
        if (sel == 2) begin start2 = s; data2 = d; count2 = c; end
        else          begin start0 = s; data0 = d; count0 = c; end
    endtask

    // Expected per-cycle trace, cycle 1 after the accepting edge onward.
    task automatic build(input logic [3:0] d, input logic [7:0] c, input int g);
        int n;
        exp_q.delete();
        n = (c == 0) ? 1 : int'(c);
        for (int r = 0; r < n; r++) begin
            for (int b = 3; b >= 0; b--) exp_q.push_back('{w: d[b], v: 1'b1, rdy: 1'b0, dn: 1'b0});
            if (r < n - 1)
                for (int k = 0; k < g; k++) exp_q.push_back('{w: 1'b1, v: 1'b0, rdy: 1'b0, dn: 1'b0});
        end
        exp_q.push_back('{w: 1'b1, v: 1'b0, rdy: 1'b1, dn: 1'b1});
    endtask

    task automatic wait_ready();
        logic [3:0] s;
        int n = 0;
        s = cur();
        while (s[3] !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            s = cur();
            n++;
        end
        if (s[3] !== 1'b1) chk("ready_timeout", 32'(s[3]), 32'd1);
    endtask

    // Accept one transfer and follow it to done. With hold set, start stays
    // high and data is replaced by alt for the whole run.
    task automatic run(input logic [3:0] d, input logic [7:0] c, input logic hold,
                       input logic [3:0] alt, output logic [63:0] ob, output int onb,
                       output int odc, output int oz);
        logic [3:0] s;
        logic [3:0] h;
        cyc_t e;
        int cyc;
        build(d, c, (sel == 2) ? 2 : 0);
        wait_ready();
        drive(1'b1, d, c);
        @(posedge clk); #1;
        drive(hold, hold ? alt : d, c);
        ob = '0; onb = 0; odc = 0; oz = 0; h = 4'b1111; cyc = 0;
        while (odc == 0 && cyc < 200) begin
            cyc++;
            s = cur();
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cycle", 32'(s), 32'({e.rdy, e.w, e.v, e.dn}));
            end else begin
                chk("overrun", 32'd1, 32'd0);
            end
            if (s[1]) begin ob = {ob[62:0], s[2]}; onb++; end
            h = {h[2:0], s[2]};
            if (h == PAT_0011) oz++;
            if (s[0]) odc = cyc;
            else begin @(posedge clk); #1; end
        end
        if (odc == 0) chk("done_timeout", 32'd0, 32'd1);
        drive(1'b0, d, c);
    endtask

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{sel: 0, d: 4'b0011, c: 8'd1, bits: 16'b0011,         nb: 4,  dcyc: 5,  z: 1};
        tbl[1] = '{sel: 0, d: 4'b0011, c: 8'd3, bits: 16'b001100110011, nb: 12, dcyc: 13, z: 3};
        tbl[2] = '{sel: 2, d: 4'b0011, c: 8'd2, bits: 16'b00110011,     nb: 8,  dcyc: 11, z: 2};
        tbl[3] = '{sel: 0, d: 4'b0011, c: 8'd0, bits: 16'b0011,         nb: 4,  dcyc: 5,  z: 1};
        tbl[4] = '{sel: 0, d: 4'b1010, c: 8'd2, bits: 16'b10101010,     nb: 8,  dcyc: 9,  z: 0};

        rst = 1'b1;
        start0 = 1'b0; start2 = 1'b0;
        data0 = '0; data2 = '0; count0 = '0; count2 = '0;
        sel = 0;
        repeat (2) @(posedge clk);
        #1;
        sel = 0; chk("reset_dut0", 32'(cur()), 32'b1100);
        sel = 2; chk("reset_dut2", 32'(cur()), 32'b1100);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 5; i++) begin
            sel = tbl[i].sel;
            run(tbl[i].d, tbl[i].c, 1'b0, 4'b0, bits, nb, dc, zc);
            chk("tbl_bits", 32'(bits[15:0]), 32'(tbl[i].bits));
            chk("tbl_nbits", 32'(nb), 32'(tbl[i].nb));
            chk("tbl_done_cyc", 32'(dc), 32'(tbl[i].dcyc));
            chk("tbl_z", 32'(zc), 32'(tbl[i].z));
            @(posedge clk); #1;
            chk("tbl_done_drop", 32'(cur()), 32'b1100);
        end

        // start held high and data changed mid-run: original pattern completes
        sel = 0;
        run(4'b0011, 8'd1, 1'b1, 4'b1111, bits, nb, dc, zc);
        chk("hold_bits", 32'(bits[3:0]), 32'b0011);
        chk("hold_done_cyc", 32'(dc), 32'd5);
        @(posedge clk); #1;
        chk("hold_idle_after", 32'(cur()), 32'b1100);

        // Asynchronous reset during bit 2
        sel = 0;
        wait_ready();
        drive(1'b1, 4'b0011, 8'd3);
        @(posedge clk); #1;
        drive(1'b0, 4'b0011, 8'd3);
        chk("rst_bit1", 32'(cur()), 32'b0010);
        @(posedge clk); #1;
        chk("rst_bit2", 32'(cur()), 32'b0010);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", 32'(cur()), 32'b1100);
        @(posedge clk); #1;
        chk("rst_held", 32'(cur()), 32'b1100);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_no_done", 32'(cur()), 32'b1100);
        run(4'b0110, 8'd2, 1'b0, 4'b0, bits, nb, dc, zc);
        chk("rst_after_bits", 32'(bits[7:0]), 32'b01100110);
        chk("rst_after_done", 32'(dc), 32'd9);

        // Randomized transfers, back-to-back where the same instance repeats
        for (int i = 0; i < 24; i++) begin
            logic [3:0] d;
            logic [7:0] c;
            int n, g;
            sel = ($urandom_range(0, 1) == 1) ? 2 : 0;
            d = 4'($urandom);
            c = 8'($urandom_range(0, 4));
            n = (c == 0) ? 1 : int'(c);
            g = (sel == 2) ? 2 : 0;
            run(d, c, 1'b0, 4'b0, bits, nb, dc, zc);
            chk("rnd_nbits", 32'(nb), 32'(n * W));
            chk("rnd_done_cyc", 32'(dc), 32'(n * W + (n - 1) * g + 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
